// File: rtl/keypad_emulator_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//   Shared definitions for the 4x4 matrix-keypad emulator and the scanner
//   bench that talks to it.
//   - KEY_0..KEY_F : key codes, code[3:2] = row index, code[1:0] = col index
//   - state_t      : emulator state machine encoding
//   - ROW_IDLE     : row value when no contact is closed (active-low lines)
//   - COL_IDLE     : column value the synchronizer holds during reset
//   - code_row_idx / code_col_idx : split a key code into matrix indices
//   - max_of       : integer max, used for counter sizing
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam logic [3:0] ROW_IDLE = 4'b1111;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [1:0] code_row_idx(input logic [3:0] code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] code_col_idx(input logic [3:0] code);
        return code[1:0];
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// ---------------------------------------------------------------------------
// keypad_emulator_if
//   Key-injection port of the keypad emulator.
//   master (injector) : drives req_valid, req_code, cancel
//   slave  (emulator) : drives req_ready, key_down, done, state_dbg
//
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both high; req_code is captured on that edge. req_ready
//   is a registered function of emulator state only and never looks at
//   req_valid. req_valid while req_ready is low is dropped, not queued.
//   cancel is a level sampled every cycle; it only has effect while a key
//   is being held. done pulses for one cycle when the release gap ends.
//   state_dbg exposes the emulator state machine for observation.
// ---------------------------------------------------------------------------
interface keypad_emulator_if;
    import keypad_pkg::*;

    logic       req_valid;
    logic [3:0] req_code;
    logic       req_ready;
    logic       cancel;
    logic       key_down;
    logic       done;
    state_t     state_dbg;

    modport master (
        output req_valid, req_code, cancel,
        input  req_ready, key_down, done, state_dbg
    );

    modport slave (
        input  req_valid, req_code, cancel,
        output req_ready, key_down, done, state_dbg
    );

endinterface

// File: rtl/keypad_emulator_sync2.sv
// ---------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer for a bus of independent level signals.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, loads rst_val into both stages
//   rst_val : value held by both stages during reset (tie to a constant)
//   d       : asynchronous input
//   q       : synchronized output, two clk edges behind d
// ---------------------------------------------------------------------------
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
//   Responder side of a 4x4 matrix keypad. Takes one key code per request,
//   closes the emulated contact for HOLD_CYCLES, then opens it and enforces
//   a GAP_CYCLES release gap before accepting the next request. While the
//   contact is closed, row[r] follows the synchronized col[c] of that key.
//
//   Ports
//     clk      : system clock
//     reset_n  : asynchronous active-low reset
//     col[3:0] : column drive from the scanner, active-low, asynchronous
//     row[3:0] : emulated row sense lines, active-low, idle 4'b1111
//     req_if   : key-injection port (keypad_emulator_if.slave)
//
//   Build option
//     KEYPAD_EMULATOR_BOUNCE_EN : contact chatters for the first
//       BOUNCE_CYCLES of both PRESS and RELEASE, toggling every
//       BOUNCE_PERIOD cycles. Undefined: the contact is clean.
// ---------------------------------------------------------------------------
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 2000000,
    parameter int GAP_CYCLES    = 1000000,
    parameter int BOUNCE_CYCLES = 250000,
    parameter int BOUNCE_PERIOD = 25000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       col,
    output logic [3:0]       row,
    keypad_emulator_if.slave req_if
);

    // The toggle period is always shorter than the chatter window in a
    // meaningful configuration, so including it never widens the counter.
    localparam int CNT_W = $clog2(max_of(max_of(HOLD_CYCLES, GAP_CYCLES),
                                         max_of(BOUNCE_CYCLES, BOUNCE_PERIOD)) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [3:0]       col_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             key_down_q, key_down_d;   // emulated contact closed
    logic [3:0]       row_q, row_d;
    logic             req_ready_q, req_ready_d;
    logic             done_q, done_d;

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    localparam int               PER_W      = $clog2(BOUNCE_PERIOD + 1);
    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(BOUNCE_PERIOD - 1);
    localparam logic [PER_W-1:0] PER_ONE    = PER_W'(1);
    localparam logic [CNT_W-1:0] BOUNCE_LIM = CNT_W'(BOUNCE_CYCLES);

    logic [PER_W-1:0] per_q, per_d;
`endif

    sync2 #(.WIDTH(4)) u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rst_val (COL_IDLE),
        .d       (col),
        .q       (col_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        key_down_d = key_down_q;
        done_d     = 1'b0;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
        per_d      = per_q;
`endif

        unique case (state_q)
            IDLE: begin
                key_down_d = 1'b0;
                // cancel is deliberately not looked at here, so a request
                // arriving together with cancel is simply accepted.
                if (req_if.req_valid && req_ready_q) begin
                    state_d    = PRESS;
                    cnt_d      = '0;
                    code_d     = req_if.req_code;
                    key_down_d = 1'b1;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
                    per_d      = '0;
`endif
                end
            end

            PRESS: begin
                if (req_if.cancel || (cnt_q == HOLD_LAST)) begin
                    state_d    = RELEASE;
                    cnt_d      = '0;
                    key_down_d = 1'b0;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
                    per_d      = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
                    // cnt_d is the index of the coming cycle; chatter
                    // stays inside the first BOUNCE_CYCLES of the phase.
                    if (cnt_d < BOUNCE_LIM) begin
                        if (per_q == PER_LAST) begin
                            key_down_d = ~key_down_q;
                            per_d      = '0;
                        end else begin
                            per_d = per_q + PER_ONE;
                        end
                    end else begin
                        key_down_d = 1'b1;
                    end
`else
                    key_down_d = 1'b1;
`endif
                end
            end

            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    key_down_d = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
                    if (cnt_d < BOUNCE_LIM) begin
                        if (per_q == PER_LAST) begin
                            key_down_d = ~key_down_q;
                            per_d      = '0;
                        end else begin
                            per_d = per_q + PER_ONE;
                        end
                    end else begin
                        key_down_d = 1'b0;
                    end
`else
                    key_down_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                key_down_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == IDLE);

        // Row is computed from next-cycle contact and code so it changes
        // on the same edge as key_down; col_s adds the synchronizer delay.
        row_d = ROW_IDLE;
        if (key_down_d && !col_s[code_col_idx(code_d)]) begin
            row_d[code_row_idx(code_d)] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            key_down_q  <= 1'b0;
            row_q       <= ROW_IDLE;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            per_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            key_down_q  <= key_down_d;
            row_q       <= row_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            per_q       <= per_d;
`endif
        end
    end

    assign row              = row_q;
    assign req_if.req_ready = req_ready_q;
    assign req_if.key_down  = key_down_q;
    assign req_if.done      = done_q;
    assign req_if.state_dbg = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_emulator
//   Self-checking bench for keypad_emulator with HOLD=20, GAP=10,
//   BOUNCE_CYCLES=6, BOUNCE_PERIOD=2. Inputs change and outputs are
//   sampled on the falling clock edge. A behavioural column scanner
//   decodes the emulated key; injected codes wait in exp_q until decoded.
//   With KEYPAD_EMULATOR_BOUNCE_EN the contact-chatter pattern is checked.
// ---------------------------------------------------------------------------
module tb_keypad_emulator;
    import keypad_pkg::*;

    localparam int HOLD   = 20;
    localparam int GAP    = 10;
    localparam int BOUNCE = 6;
    localparam int PER    = 2;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       reset_n;
    logic [3:0] col;
    logic [3:0] row;

    keypad_emulator_if kif ();

    keypad_emulator #(
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .BOUNCE_CYCLES (BOUNCE),
        .BOUNCE_PERIOD (PER)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .col     (col),
        .row     (row),
        .req_if  (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / checking ----------------
    logic [3:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // per-run statistics, cycle index counted in falling edges
    int   mcyc, kd_cnt, busy_cnt, done_cnt, fall_at, done_at;
    logic kd_prev, rdy_at_done;

    task automatic clear_stats();
        mcyc        = 0;
        kd_cnt      = 0;
        busy_cnt    = 0;
        done_cnt    = 0;
        fall_at     = -1;
        done_at     = -1;
        kd_prev     = kif.key_down;
        rdy_at_done = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mcyc++;
            if (kif.key_down) kd_cnt++;
            if (kd_prev && !kif.key_down) fall_at = mcyc;
            kd_prev = kif.key_down;
            if (!kif.req_ready) busy_cnt++;
            if (kif.done) begin
                done_cnt++;
                done_at     = mcyc;
                rdy_at_done = kif.req_ready;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns 1 time unit after the accepting edge.
    task automatic accept(input logic [3:0] code);
        int w;
        w = 0;
        while (!kif.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!kif.req_ready) check_val("accept_wait", 32'(kif.req_ready), 32'd1);
        kif.req_valid = 1'b1;
        kif.req_code  = code;
        @(posedge clk);
        #1;
        kif.req_valid = 1'b0;
    endtask

    task automatic settle_col(input logic [3:0] value);
        col = value;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [4:0] decode_hit(input logic [3:0] r, input int s);
        logic [4:0] v;
        v = 5'h1F;
        case (r)
            4'b1110: v = {1'b0, 2'd0, 2'(s)};
            4'b1101: v = {1'b0, 2'd1, 2'(s)};
            4'b1011: v = {1'b0, 2'd2, 2'(s)};
            4'b0111: v = {1'b0, 2'd3, 2'(s)};
            default: v = 5'h1F;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] walk_col(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << s);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int         row_bad;
        int         idle_bad;
        logic       found;
        logic [4:0] dec;
        logic [3:0] c4;
        logic       exp_kd;

        reset_n       = 1'b0;
        col           = 4'b1111;
        kif.req_valid = 1'b0;
        kif.req_code  = 4'h0;
        kif.cancel    = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst_row",      32'(row),           32'(4'b1111));
        check_val("rst_ready",    32'(kif.req_ready), 32'd1);
        check_val("rst_key_down", 32'(kif.key_down),  32'd0);
        check_val("rst_done",     32'(kif.done),      32'd0);
        check_val("rst_state",    32'(kif.state_dbg), 32'(IDLE));
        reset_n = 1'b1;
        @(negedge clk);

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
        // ---- contact chatter on code 5 ----
        settle_col(4'b1111);
        clear_stats();
        accept(KEY_5);
        for (int k = 0; k < HOLD; k++) begin
            run_cycles(1);
            exp_kd = (k < BOUNCE) ? (((k / PER) % 2) == 0) : 1'b1;
            check_val($sformatf("bounce_press_%0d", k), 32'(kif.key_down), 32'(exp_kd));
        end
        for (int k = 0; k < GAP; k++) begin
            run_cycles(1);
            exp_kd = (k < BOUNCE) ? (((k / PER) % 2) == 1) : 1'b0;
            check_val($sformatf("bounce_release_%0d", k), 32'(kif.key_down), 32'(exp_kd));
        end
        run_cycles(1);
        check_val("bounce_done", 32'(kif.done), 32'd1);
`else
        // ---- code 6, column 2 driven ----
        settle_col(4'b1011);
        clear_stats();
        accept(KEY_6);
        run_cycles(1);
        check_val("t1_row_press", 32'(row), 32'(4'b1101));
        col = 4'b1110;
        run_cycles(2);
        check_val("t1_row_lat2", 32'(row), 32'(4'b1101));
        run_cycles(1);
        check_val("t1_row_lat3", 32'(row), 32'(4'b1111));
        col = 4'b1011;
        run_cycles(3);
        check_val("t1_row_back", 32'(row), 32'(4'b1101));
        run_cycles(30);
        check_val("t1_kd_cycles", 32'(kd_cnt),             32'(HOLD));
        check_val("t1_kd_fall",   32'(fall_at),            32'(HOLD + 1));
        check_val("t1_done_gap",  32'(done_at - fall_at),  32'(GAP));
        check_val("t1_done_cnt",  32'(done_cnt),           32'd1);
        check_val("t1_busy",      32'(busy_cnt),           32'(HOLD + GAP));

        // ---- code 0, idle probe col=0000, ignored second request ----
        settle_col(4'b0000);
        clear_stats();
        accept(KEY_0);
        row_bad  = 0;
        idle_bad = 0;
        for (int k = 0; k < 45; k++) begin
            run_cycles(1);
            if (kif.key_down && row != 4'b1110) row_bad++;
            if (!kif.key_down && row != 4'b1111) idle_bad++;
            if (mcyc == 5) begin
                kif.req_valid = 1'b1;
                kif.req_code  = KEY_3;
            end
            if (mcyc == 25) kif.req_valid = 1'b0;
        end
        check_val("t2_row_pressed", 32'(row_bad),     32'd0);
        check_val("t2_row_idle",    32'(idle_bad),    32'd0);
        check_val("t2_kd_cycles",   32'(kd_cnt),      32'(HOLD));
        check_val("t2_busy",        32'(busy_cnt),    32'(HOLD + GAP));
        check_val("t2_ready_done",  32'(rdy_at_done), 32'd1);
        check_val("t2_done_cnt",    32'(done_cnt),    32'd1);
        check_val("t2_state_end",   32'(kif.state_dbg), 32'(IDLE));

        // ---- code 15, cancel on press cycle 5 ----
        settle_col(4'b0111);
        clear_stats();
        accept(KEY_F);
        run_cycles(5);
        check_val("t3_row_pressed", 32'(row),          32'(4'b0111));
        check_val("t3_kd_before",   32'(kif.key_down), 32'd1);
        kif.cancel = 1'b1;
        run_cycles(1);
        kif.cancel = 1'b0;
        check_val("t3_kd_after",    32'(kif.key_down), 32'd0);
        check_val("t3_row_after",   32'(row),          32'(4'b1111));
        run_cycles(14);
        check_val("t3_kd_cycles",   32'(kd_cnt),            32'd5);
        check_val("t3_done_gap",    32'(done_at - fall_at), 32'(GAP));
        check_val("t3_total_busy",  32'(busy_cnt + 1),      32'd16);
        check_val("t3_done_cnt",    32'(done_cnt),          32'd1);

        // ---- code 9, reset during PRESS ----
        settle_col(4'b1101);
        clear_stats();
        accept(KEY_9);
        run_cycles(5);
        check_val("t4_row_pressed", 32'(row), 32'(4'b1011));
        reset_n = 1'b0;
        #1;
        check_val("t4_rst_row",   32'(row),           32'(4'b1111));
        check_val("t4_rst_ready", 32'(kif.req_ready), 32'd1);
        check_val("t4_rst_kd",    32'(kif.key_down),  32'd0);
        clear_stats();
        run_cycles(3);
        reset_n = 1'b1;
        check_val("t4_no_done", 32'(done_cnt), 32'd0);
        accept(KEY_9);
        run_cycles(1);
        check_val("t4_reaccept_kd",    32'(kif.key_down),  32'd1);
        check_val("t4_reaccept_state", 32'(kif.state_dbg), 32'(PRESS));
        run_cycles(35);
        check_val("t4_kd_cycles", 32'(kd_cnt),   32'(HOLD));
        check_val("t4_done_cnt",  32'(done_cnt), 32'd1);

        // ---- all 16 codes through a behavioural column scanner ----
        // Each press covers two 8-cycle column steps; columns 2 and 3 are
        // walked on a second press of the same key.
        for (int code = 0; code < 16; code++) begin
            c4 = 4'(code);
            exp_q.push_back(c4);
            found = 1'b0;
            dec   = 5'h1F;
            for (int half = 0; half < 2; half++) begin
                if (!found) begin
                    col = walk_col(2 * half);
                    accept(c4);
                    for (int s = 2 * half; s < 2 * half + 2; s++) begin
                        col = walk_col(s);
                        repeat (8) @(negedge clk);
                        if (!found && row != ROW_IDLE) begin
                            found = 1'b1;
                            dec   = decode_hit(row, s);
                        end
                    end
                end
            end
            if (found) check_val($sformatf("scan_code_%0d", code), 32'(dec), 32'(exp_q.pop_front()));
            else       check_val($sformatf("scan_seen_%0d", code), 32'(found), 32'(exp_q.pop_front() != 4'hx));
        end
        check_val("scan_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Responder side of the 4x4 matrix-keypad interface: drives the row lines in reply to the column scan pattern, emulating a physical key press.
- Driven by an internal source (self-test sequencer or remote key injection). Lets the keyboard scanner and the clock's key-handling logic run on-board without a physical keypad.
- Accepts one key code per request; holds it pressed for a set time, then releases it and enforces a gap before accepting the next request.

Parameters:
- HOLD_CYCLES, 2000000, clk cycles the key stays pressed (40 ms at 50 MHz); must be >= 1.
- GAP_CYCLES, 1000000, clk cycles of forced release after a press (20 ms); must be >= 1.
- BOUNCE_CYCLES, 250000, length of the chatter window at press and at release; used only with the optional feature.
- BOUNCE_PERIOD, 25000, chatter toggle interval; used only with the optional feature.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- col  in  4  column drive from the scanner, active-low; asynchronous to clk.
- row  out  4  emulated row sense lines, active-low; idle value 4'b1111.
- req_valid  in  1  key-injection request.
- req_code  in  4  key code: code[3:2] = row index, code[1:0] = column index.
- req_ready  out  1  high when a request can be accepted.
- cancel  in  1  abort the current press and go straight to the release gap.
- key_down  out  1  high while the emulated contact is closed.
- done  out  1  one-cycle pulse when the gap ends.

Behaviour:
- Reset (asynchronous, active-low) returns every register to its reset value:
  - row=4'b1111, req_ready=1, key_down=0, done=0, state=IDLE, counter=0, latched code=0.
- Column synchronizer:
  - col passes through a 2-flop synchronizer to give col_s.
  - The 2-flop stages reset to 4'b1111.
- Row generation (registered):
  - r = code[3:2], c = code[1:0].
  - Next row[r] = 0 iff contact closed AND col_s[c]==0. All other row bits are 1.
  - Latency from a col edge to the row response is 3 clk cycles.
  - col=4'b0000 (scanner idle probe) therefore pulls row[r] low while the key is pressed.
- Key code mapping: code 0 gives row 1110 / col 1110; code 1 gives row 1110 / col 1101; code 4 gives row 1101 / col 1110; code 15 gives row 0111 / col 0111.
- Handshake:
  - A transfer occurs when req_valid && req_ready at a clk edge. req_code is latched on that edge.
  - req_ready=1 only in IDLE and depends on state alone, with no combinational path from req_valid.
  - req_valid while not ready is ignored. No queueing.
- State machine:
  - IDLE: row=1111, key_down=0.
    - On transfer: go to PRESS, counter=0, key_down=1 on the next cycle.
  - PRESS: counter increments each cycle.
    - When counter==HOLD_CYCLES-1: go to RELEASE, counter=0, key_down=0.
    - If cancel=1: go to RELEASE immediately, counter=0.
  - RELEASE: row is forced to 1111; counter increments.
    - When counter==GAP_CYCLES-1: go to IDLE and pulse done for 1 cycle.
    - cancel is ignored.
- cancel in IDLE is ignored. If cancel and a transfer coincide in IDLE, the transfer wins.
- key_down is high for exactly HOLD_CYCLES cycles when no cancel occurs.
- Counter width is $clog2(max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES)+1).
- Reset asserted mid-press: row returns to 1111 asynchronously and the request is lost. done does not pulse.
- Back-to-back requests: the minimum request spacing is HOLD_CYCLES+GAP_CYCLES+1 cycles.

Optional Feature:
- Macro: KEYPAD_EMULATOR_BOUNCE_EN.
- Defined:
  - During the first BOUNCE_CYCLES of PRESS, the contact toggles every BOUNCE_PERIOD cycles, starting closed.
  - During the first BOUNCE_CYCLES of RELEASE, the contact toggles again, starting open.
  - key_down reflects the actual contact state.
  - HOLD_CYCLES and GAP_CYCLES include the chatter windows.
  - A dedicated period counter drives the toggling.
- Undefined: the contact is clean (closed for all of PRESS, open for all of RELEASE). The period counter and the chatter logic are absent.

Decomposition:
- Package keypad_pkg holds:
  - Key code constants KEY_0..KEY_F.
  - The state enum (IDLE, PRESS, RELEASE).
  - Functions code_row_idx(code) and code_col_idx(code), shared with the scanner bench.
  - Constant ROW_IDLE = 4'b1111.
- Sub-module sync2 (parameterised width, reset value input) for the column synchronizer.

Test Plan:
- All tests use HOLD_CYCLES=20, GAP_CYCLES=10, BOUNCE_CYCLES=6, BOUNCE_PERIOD=2.
- Code 6, col driven 1011: row=1101 three cycles after the press starts; col=1110 gives row=1111; key_down high for exactly 20 cycles; done pulses 10 cycles after key_down falls.
- Code 0 with col held at 0000: row=1110 throughout PRESS; req_ready low from the accept until the done cycle; a second req_valid during PRESS is ignored (no second press).
- Code 15 with cancel on press cycle 5: key_down falls the next cycle; row=1111; done after 10 more cycles; total busy = 16 cycles.
- Reset_n low during PRESS of code 9: row=1111 and req_ready=1 immediately; no done pulse; a new request is accepted on the cycle after reset deasserts.
- Loop all 16 codes with a behavioural scanner (col walk 1110, 1101, 1011, 0111, 8 clk per step): decoded code equals the injected code in every case.
- With KEYPAD_EMULATOR_BOUNCE_EN, code 5: key_down pattern 1,1,0,0,1,1 then steady 1 until cycle 20; release 0,0,1,1,0,0 then steady 0.
